mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Sequences and shares the single-port 32x16 unified memory between three requesters: the program loader (LDR, write-only), the data-access stage (DAT, read/write) and the instruction-fetch unit (IFU, read-only).
- Drives the memory's active-low read/write strobes, address and write data.
- Returns read data and a one-cycle acknowledge to the winning requester.
- Sits between the multicycle CPU control/loader and the memory macro, which acts on the falling clock edge.

Parameters:
AW, 5, address width in bits
DW, 16, data width in bits
WAIT_MAX, 4, DAT grants allowed while IFU waits before IFU gains priority over DAT (range 1..15)

Ports:
clk  in  1  system clock; all state updates on the rising edge
proc_rst  in  1  asynchronous, active-high reset
ldr_req  in  1  loader write request
ldr_addr  in  AW  loader address
ldr_wdata  in  DW  loader write data
ldr_ack  out  1  loader done pulse
dat_req  in  1  data request
dat_we  in  1  1 = write, 0 = read
dat_addr  in  AW  data address
dat_wdata  in  DW  data write data
dat_ack  out  1  data done pulse
dat_rdata  out  DW  data read result
ifu_req  in  1  fetch request (read)
ifu_addr  in  AW  fetch address
ifu_ack  out  1  fetch done pulse
ifu_rdata  out  DW  fetched instruction
mem_address  out  AW  to memory address
mem_in  out  DW  to memory write data
mem_write_n  out  1  memory write strobe, active-low
mem_read_n  out  1  memory read strobe, active-low
mem_out  in  DW  memory read data, valid after memory's falling edge
grant_id  out  2  current owner: 0 none, 1 IFU, 2 DAT, 3 LDR
busy  out  1  high in ACCESS or RESP

Behaviour:
- Reset, asynchronous: state IDLE, grant_id 0, all acks 0, mem_write_n and mem_read_n 1, mem_address 0, mem_in 0, dat_rdata 0, ifu_rdata 0, age counter 0. Reset mid-transaction aborts it with no ack; strobes deassert immediately.
- All outputs are registered.
- FSM states:
  - IDLE: any eligible req goes to ACCESS at the next edge. The edge latches winner, address and wdata, sets strobes and sets grant_id.
  - ACCESS, exactly 1 cycle: exactly one strobe low (write for LDR and DAT with we=1, else read). The memory acts at the falling edge. Exits to RESP.
  - RESP, 1 cycle: strobes 1, winner's ack = 1.
    - For a read, the winner's rdata is loaded at the ACCESS→RESP edge from mem_out and is valid while ack = 1.
    - Exits to ACCESS if another eligible req exists, else IDLE with grant_id 0.
- Latency: req high in cycle 0 (IDLE) gives ack in cycle 2. Peak throughput is one access per 2 cycles.
- Requester holds req and payload until ack. Payload is latched at grant; later changes are ignored.
- Eligibility: in RESP the just-served port's req is ignored, because it is still the old request. That port may present a new request from the cycle after ack.
- Priority: LDR > DAT > IFU, except that IFU > DAT when age == WAIT_MAX. LDR always wins.
- Age counter:
  - Increments, saturating at WAIT_MAX, on each DAT grant while ifu_req = 1.
  - Clears on an IFU grant or whenever ifu_req = 0.
- Writes do not modify dat_rdata. rdata registers hold their last read value.
- Exactly one ack pulses per transaction. Acks are never high in IDLE or ACCESS. mem_write_n and mem_read_n are never both 0.
- Address wrap: none. AW bits index the full memory.

Decomposition:
- Package mem_arb_pkg:
  - State encoding IDLE/ACCESS/RESP.
  - Grant-id constants GNT_NONE=0, GNT_IFU=1, GNT_DAT=2, GNT_LDR=3.
  - Default widths AW/DW.
- Sub-module mem_arb_pick: combinational picker.
  - Inputs: three reqs, age-expired flag, last-served id for RESP exclusion.
  - Output: winner id.
  - Keeps the FSM and datapath registers in the top.

Test Plan:
- Reset then DAT write addr 3 data 16'hBEEF, next DAT read addr 3 -> mem_write_n low exactly one cycle, dat_ack in cycle 2 of each, dat_rdata = 16'hBEEF during read ack.
- ldr_req, dat_req, ifu_req all raised the same cycle, each doing one transaction -> grant order LDR, DAT, IFU, acks at cycles 2, 4, 6, no IDLE gaps.
- WAIT_MAX=4, dat_req held continuously with new transactions, ifu_req held -> IFU granted after the 4th DAT grant, age clears, then DAT resumes.
- IFU read addr 0 after LDR writes 16'h02F0 to addr 0 -> ifu_rdata = 16'h02F0 with ifu_ack; dat_rdata unchanged.
- Assert proc_rst during ACCESS of a DAT write -> strobes return to 1 asynchronously, no dat_ack, state IDLE, grant_id 0; after release a new DAT request completes normally.
- Change dat_addr and dat_wdata the cycle after grant -> memory sees the originally latched values; ack still in cycle 2.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter:
// FSM state encoding, grant identifiers and default bus widths.
package mem_arb_pkg;

  localparam int AW_DEF = 5;
  localparam int DW_DEF = 16;
  localparam int AGE_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IFU  = 2'd1;
  localparam logic [1:0] GNT_DAT  = 2'd2;
  localparam logic [1:0] GNT_LDR  = 2'd3;

  // Loader traffic is always a write; the data stage writes only when dat_we is set.
  function automatic logic is_write(input logic [1:0] gnt, input logic dat_we);
    return (gnt == GNT_LDR) || ((gnt == GNT_DAT) && dat_we);
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection: LDR > DAT > IFU, with IFU promoted above
// DAT once it has aged out. The port just served is masked during RESP.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic       i_ldr_req,
  input  logic       i_dat_req,
  input  logic       i_ifu_req,
  input  logic       i_age_expired,
  input  logic [1:0] i_last_id,
  output logic [1:0] o_winner
);

  logic w_ldr_elig;
  logic w_dat_elig;
  logic w_ifu_elig;

  // The port acked in RESP still shows its old request, so it sits this round out.
  assign w_ldr_elig = i_ldr_req && (i_last_id != GNT_LDR);
  assign w_dat_elig = i_dat_req && (i_last_id != GNT_DAT);
  assign w_ifu_elig = i_ifu_req && (i_last_id != GNT_IFU);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    o_winner = GNT_NONE;
    if (w_ldr_elig) begin
      o_winner = GNT_LDR;
    end else if (w_ifu_elig && i_age_expired) begin
      o_winner = GNT_IFU;
    end else if (w_dat_elig) begin
      o_winner = GNT_DAT;
    end else if (w_ifu_elig) begin
      o_winner = GNT_IFU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port unified memory between loader, data stage and fetch:
// IDLE -> ACCESS (one strobe low) -> RESP (ack), all outputs registered.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter int WAIT_MAX = 4
) (
  input  logic          clk,
  input  logic          proc_rst,
  input  logic          ldr_req,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic          ldr_ack,
  input  logic          dat_req,
  input  logic          dat_we,
  input  logic [AW-1:0] dat_addr,
  input  logic [DW-1:0] dat_wdata,
  output logic          dat_ack,
  output logic [DW-1:0] dat_rdata,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  output logic          ifu_ack,
  output logic [DW-1:0] ifu_rdata,
  output logic [AW-1:0] mem_address,
  output logic [DW-1:0] mem_in,
  output logic          mem_write_n,
  output logic          mem_read_n,
  input  logic [DW-1:0] mem_out,
  output logic [1:0]    grant_id,
  output logic          busy
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(WAIT_MAX);

  state_t r_state;
  state_t w_next_state;

  logic [1:0]       r_grant_id;
  logic [AW-1:0]    r_mem_address;
  logic [DW-1:0]    r_mem_in;
  logic             r_mem_write_n;
  logic             r_mem_read_n;
  logic             r_ldr_ack;
  logic             r_dat_ack;
  logic             r_ifu_ack;
  logic [DW-1:0]    r_dat_rdata;
  logic [DW-1:0]    r_ifu_rdata;
  logic             r_busy;
  logic [AGE_W-1:0] r_age;

  logic [1:0]    w_last_id;
  logic [1:0]    w_winner;
  logic          w_grant;
  logic          w_write;
  logic          w_age_expired;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  assign w_last_id     = (r_state == ST_RESP) ? r_grant_id : GNT_NONE;
  assign w_age_expired = (r_age == AGE_MAX);

  mem_arb_pick u_pick (
    .i_ldr_req     (ldr_req),
    .i_dat_req     (dat_req),
    .i_ifu_req     (ifu_req),
    .i_age_expired (w_age_expired),
    .i_last_id     (w_last_id),
    .o_winner      (w_winner)
  );

  // A new grant can only be issued from IDLE or RESP; ACCESS is a fixed single cycle.
  assign w_grant = (r_state != ST_ACCESS) && (w_winner != GNT_NONE);
  assign w_write = is_write(w_winner, dat_we);

  always_comb begin
    w_sel_addr  = r_mem_address;
    w_sel_wdata = r_mem_in;
    case (w_winner)
      GNT_LDR: begin
        w_sel_addr  = ldr_addr;
        w_sel_wdata = ldr_wdata;
      end
      GNT_DAT: begin
        w_sel_addr  = dat_addr;
        w_sel_wdata = dat_wdata;
      end
      GNT_IFU: begin
        w_sel_addr  = ifu_addr;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   w_next_state = w_grant ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: w_next_state = ST_RESP;
      ST_RESP:   w_next_state = w_grant ? ST_ACCESS : ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      r_grant_id    <= GNT_NONE;
      r_mem_address <= '0;
      r_mem_in      <= '0;
      r_mem_write_n <= 1'b1;
      r_mem_read_n  <= 1'b1;
      r_ldr_ack     <= 1'b0;
      r_dat_ack     <= 1'b0;
      r_ifu_ack     <= 1'b0;
      r_dat_rdata   <= '0;
      r_ifu_rdata   <= '0;
      r_busy        <= 1'b0;
    end else begin
      r_ldr_ack <= 1'b0;
      r_dat_ack <= 1'b0;
      r_ifu_ack <= 1'b0;
      case (r_state)
        ST_ACCESS: begin
          r_mem_write_n <= 1'b1;
          r_mem_read_n  <= 1'b1;
          r_busy        <= 1'b1;
          r_ldr_ack     <= (r_grant_id == GNT_LDR);
          r_dat_ack     <= (r_grant_id == GNT_DAT);
          r_ifu_ack     <= (r_grant_id == GNT_IFU);
          // mem_out was refreshed by the macro on the falling edge inside ACCESS.
          if (!r_mem_read_n && (r_grant_id == GNT_DAT)) begin
            r_dat_rdata <= mem_out;
          end
          if (!r_mem_read_n && (r_grant_id == GNT_IFU)) begin
            r_ifu_rdata <= mem_out;
          end
        end
        default: begin
          if (w_grant) begin
            r_grant_id    <= w_winner;
            r_mem_address <= w_sel_addr;
            r_mem_in      <= w_sel_wdata;
            r_mem_write_n <= ~w_write;
            r_mem_read_n  <= w_write;
            r_busy        <= 1'b1;
          end else begin
            r_grant_id    <= GNT_NONE;
            r_mem_write_n <= 1'b1;
            r_mem_read_n  <= 1'b1;
            r_busy        <= 1'b0;
          end
        end
      endcase
    end
  end

  // IFU starvation guard: counts DAT grants taken while a fetch is pending.
  always_ff @(posedge clk or posedge proc_rst) begin
    if (proc_rst) begin
      r_age <= '0;
    end else if (!ifu_req) begin
      r_age <= '0;
    end else if (w_grant && (w_winner == GNT_IFU)) begin
      r_age <= '0;
    end else if (w_grant && (w_winner == GNT_DAT) && (r_age != AGE_MAX)) begin
      r_age <= r_age + 1'b1;
    end
  end

  assign ldr_ack     = r_ldr_ack;
  assign dat_ack     = r_dat_ack;
  assign ifu_ack     = r_ifu_ack;
  assign dat_rdata   = r_dat_rdata;
  assign ifu_rdata   = r_ifu_rdata;
  assign mem_address = r_mem_address;
  assign mem_in      = r_mem_in;
  assign mem_write_n = r_mem_write_n;
  assign mem_read_n  = r_mem_read_n;
  assign grant_id    = r_grant_id;
  assign busy        = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected acks,
// a negedge monitor pops and compares port, cycle and read data.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 5;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          proc_rst;
  logic          ldr_req, dat_req, dat_we, ifu_req;
  logic [AW-1:0] ldr_addr, dat_addr, ifu_addr;
  logic [DW-1:0] ldr_wdata, dat_wdata;
  logic          ldr_ack, dat_ack, ifu_ack;
  logic [DW-1:0] dat_rdata, ifu_rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_in, mem_out;
  logic          mem_write_n, mem_read_n;
  logic [1:0]    grant_id;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW), .WAIT_MAX(4)) dut (
    .clk(clk), .proc_rst(proc_rst),
    .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
    .dat_req(dat_req), .dat_we(dat_we), .dat_addr(dat_addr), .dat_wdata(dat_wdata),
    .dat_ack(dat_ack), .dat_rdata(dat_rdata),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_ack(ifu_ack), .ifu_rdata(ifu_rdata),
    .mem_address(mem_address), .mem_in(mem_in), .mem_write_n(mem_write_n),
    .mem_read_n(mem_read_n), .mem_out(mem_out), .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Memory macro model: acts on the falling edge.
  logic [DW-1:0] mem [32];
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    mem_out = '0;
  end
  always @(negedge clk) begin
    if (!mem_write_n) mem[mem_address] <= mem_in;
    if (!mem_read_n)  mem_out <= mem[mem_address];
  end

  typedef struct {
    logic [1:0]    gid;
    bit            chk;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   wr_low_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push(input logic [1:0] gid, input bit chk, input logic [DW-1:0] data,
                      input int off);
    exp_t e;
    e.gid  = gid;
    e.chk  = chk;
    e.data = data;
    e.cyc  = cyc + off;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    logic [1:0] got;
    if (!mem_write_n) wr_low_cnt <= wr_low_cnt + 1;
    if (!mem_write_n || !mem_read_n) check("strobe_excl", 32'(mem_write_n | mem_read_n), 1);
    if (ldr_ack || dat_ack || ifu_ack) begin
      check("one_ack", 32'(ldr_ack) + 32'(dat_ack) + 32'(ifu_ack), 1);
      check("busy_in_resp", 32'(busy), 1);
      if (sb.size() == 0) begin
        check("unexpected_ack", {29'd0, ldr_ack, dat_ack, ifu_ack}, 0);
      end else begin
        mon_e = sb.pop_front();
        got = ldr_ack ? GNT_LDR : (dat_ack ? GNT_DAT : GNT_IFU);
        check("ack_port", 32'(got), 32'(mon_e.gid));
        check("ack_cycle", cyc, mon_e.cyc);
        check("grant_id_resp", 32'(grant_id), 32'(mon_e.gid));
        if (mon_e.chk)
          check("rdata", 32'((mon_e.gid == GNT_IFU) ? ifu_rdata : dat_rdata), 32'(mon_e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ack(input logic [1:0] which, input string name);
    bit seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      case (which)
        GNT_LDR: seen = ldr_ack;
        GNT_DAT: seen = dat_ack;
        default: seen = ifu_ack;
      endcase
    end
    check({name, "_ack_seen"}, 32'(seen), 1);
  endtask

  task automatic ldr_do(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit keep);
    ldr_addr = a; ldr_wdata = d; ldr_req = 1'b1;
    wait_ack(GNT_LDR, "ldr");
    if (!keep) ldr_req = 1'b0;
  endtask

  task automatic dat_do(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input bit keep);
    dat_we = we; dat_addr = a; dat_wdata = d; dat_req = 1'b1;
    wait_ack(GNT_DAT, "dat");
    if (!keep) dat_req = 1'b0;
  endtask

  task automatic ifu_do(input logic [AW-1:0] a, input bit keep);
    ifu_addr = a; ifu_req = 1'b1;
    wait_ack(GNT_IFU, "ifu");
    if (!keep) ifu_req = 1'b0;
  endtask

  initial begin
    int w0;
    proc_rst = 1'b1;
    ldr_req = 0; dat_req = 0; ifu_req = 0; dat_we = 0;
    ldr_addr = '0; dat_addr = '0; ifu_addr = '0; ldr_wdata = '0; dat_wdata = '0;
    idle(3);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_strobes", {30'd0, mem_write_n, mem_read_n}, 3);
    check("rst_acks", {29'd0, ldr_ack, dat_ack, ifu_ack}, 0);
    check("rst_mem_address", 32'(mem_address), 0);
    check("rst_mem_in", 32'(mem_in), 0);
    check("rst_rdata", {dat_rdata, ifu_rdata}, 0);
    check("rst_busy", 32'(busy), 0);
    proc_rst = 1'b0;
    idle(1);

    // DAT write then read back of address 3.
    w0 = wr_low_cnt;
    push(GNT_DAT, 0, '0, 2);
    dat_do(1'b1, 5'd3, 16'hBEEF, 0);
    idle(1);
    check("wr_strobe_cycles", wr_low_cnt - w0, 1);
    push(GNT_DAT, 1, 16'hBEEF, 2);
    dat_do(1'b0, 5'd3, '0, 0);
    idle(1);

    // All three at once: LDR, DAT, IFU back to back.
    push(GNT_LDR, 0, '0, 2);
    push(GNT_DAT, 1, 16'h1234, 4);
    push(GNT_IFU, 1, 16'hBEEF, 6);
    fork
      ldr_do(5'd5, 16'h1234, 0);
      dat_do(1'b0, 5'd5, '0, 0);
      ifu_do(5'd3, 0);
    join
    idle(1);

    // Aging: LDR and DAT stream, IFU waits until the 4th DAT grant.
    push(GNT_LDR, 0, '0, 2);
    push(GNT_DAT, 0, '0, 4);
    push(GNT_LDR, 0, '0, 6);
    push(GNT_DAT, 1, 16'hA000, 8);
    push(GNT_LDR, 0, '0, 10);
    push(GNT_DAT, 0, '0, 12);
    push(GNT_LDR, 0, '0, 14);
    push(GNT_DAT, 1, 16'hA002, 16);
    push(GNT_LDR, 0, '0, 18);
    push(GNT_IFU, 1, 16'h5000, 20);
    push(GNT_LDR, 0, '0, 22);
    push(GNT_DAT, 0, '0, 24);
    fork
      begin
        for (int i = 0; i < 6; i++) ldr_do(5'(8 + i), 16'(16'h5000 + i), i < 5);
      end
      begin
        for (int i = 0; i < 5; i++) begin
          if (i % 2 == 0) dat_do(1'b1, 5'(16 + i), 16'(16'hA000 + i), i < 4);
          else            dat_do(1'b0, 5'(16 + i - 1), '0, i < 4);
        end
      end
      ifu_do(5'd8, 0);
    join
    idle(1);
    check("age_dat_write_20", 32'(mem[20]), 32'h0000A004);

    // IFU fetch of loader-written word; dat_rdata keeps its last read.
    push(GNT_LDR, 0, '0, 2);
    ldr_do(5'd0, 16'h02F0, 0);
    idle(1);
    push(GNT_IFU, 1, 16'h02F0, 2);
    ifu_do(5'd0, 0);
    check("dat_rdata_hold", 32'(dat_rdata), 32'h0000A002);
    idle(1);

    // Reset during ACCESS of a DAT write aborts it.
    dat_we = 1'b1; dat_addr = 5'd25; dat_wdata = 16'hDEAD; dat_req = 1'b1;
    idle(1);
    check("abort_access_grant", 32'(grant_id), 32'(GNT_DAT));
    check("abort_access_wr_n", 32'(mem_write_n), 0);
    proc_rst = 1'b1;
    #1;
    check("abort_strobes", {30'd0, mem_write_n, mem_read_n}, 3);
    check("abort_grant_id", 32'(grant_id), 0);
    check("abort_busy", 32'(busy), 0);
    dat_req = 1'b0;
    idle(2);
    check("abort_no_write", 32'(mem[25]), 0);
    proc_rst = 1'b0;
    idle(1);
    push(GNT_DAT, 0, '0, 2);
    dat_do(1'b1, 5'd25, 16'hC0DE, 0);
    idle(1);
    push(GNT_DAT, 1, 16'hC0DE, 2);
    dat_do(1'b0, 5'd25, '0, 0);
    idle(1);

    // Payload changes after grant must be ignored.
    push(GNT_DAT, 0, '0, 2);
    dat_we = 1'b1; dat_addr = 5'd7; dat_wdata = 16'h7777; dat_req = 1'b1;
    idle(1);
    dat_addr = 5'd30; dat_wdata = 16'h9999;
    check("latched_addr", 32'(mem_address), 7);
    check("latched_wdata", 32'(mem_in), 32'h00007777);
    wait_ack(GNT_DAT, "dat_latched");
    dat_req = 1'b0;
    idle(1);
    check("latched_mem7", 32'(mem[7]), 32'h00007777);
    check("latched_mem30", 32'(mem[30]), 0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) idle(1);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
